regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset (0 = asserted), sampled on the clk rising edge.
REQ-003 SHALL have ports wa, wd, wvalid, inputs, creg_addr_t/u64/u1, the writeback write port (destination, data, enable).
REQ-004 SHALL have ports ra1, ra2, inputs, creg_addr_t, decode read addresses.
REQ-005 SHALL have ports rd1, rd2, outputs, u64, read data for ra1/ra2.
REQ-006 SHALL have ports busy1, busy2, outputs, u1, set when ra1/ra2 has an outstanding unwritten producer.
REQ-007 SHALL have ports set_valid, set_addr, inputs, u1/creg_addr_t, marking an issued instruction's rd as pending.
REQ-008 SHALL have port flush, input, u1, clearing all pending marks (pipeline squash).
REQ-009 SHALL have port busy_cnt, output, 6 bits, number of currently pending registers (0..31).

Function
REQ-010 SHALL hold 32 x 64-bit architectural registers; register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-011 SHALL write wd into register wa at the clk edge when wvalid=1 and wa!=0.
REQ-012 SHALL produce rd1/rd2 combinationally, zero-latency.
REQ-013 SHALL bypass: if wvalid=1, wa!=0 and raN==wa in the same cycle, rdN SHALL equal wd, not the stored value.
REQ-014 SHALL keep one busy bit per register; busy[0] SHALL be constantly 0.
REQ-015 SHALL set busy[set_addr] at the edge when set_valid=1 and set_addr!=0.
REQ-016 SHALL clear busy[wa] at the edge when wvalid=1 and wa!=0.
REQ-017 When set and clear target the same register in one cycle, set SHALL win (busy stays 1).
REQ-018 flush=1 SHALL clear all busy bits at the edge and take priority over a concurrent set; a concurrent register write SHALL still occur.
REQ-019 busyN SHALL equal busy[raN] AND NOT (wvalid AND wa==raN AND wa!=0); raN==0 SHALL give busyN=0.
REQ-020 busy_cnt SHALL be registered, always equal to the population count of busy bits after each edge, updated in the same edge as the bits (no extra latency).
REQ-021 Setting an already-busy register SHALL leave busy_cnt unchanged; clearing a non-busy register SHALL leave it unchanged (no wrap below 0).

Reset
REQ-022 While reset=0 at a clk edge, all 31 registers SHALL become 0, all busy bits 0, busy_cnt 0.
REQ-023 Reset SHALL override wvalid, set_valid and flush in the same cycle.
REQ-024 After reset release, rd1/rd2=0, busy1/busy2=0 for all addresses until a write/set occurs.

Structure
REQ-025 creg_addr_t (5 bits), u64, u1 SHALL come from the common package; any busy-count width constant SHALL live in the same package.
REQ-026 Storage array and scoreboard SHALL be separate concerns; one sub-module, busy_scoreboard (busy bits, busy_cnt, REQ-014..021), is natural, instantiated once.
REQ-027 Module SHALL contain no latches; all state in clk-edge always blocks.

Verification
REQ-028 Reset, then wvalid=1, wa=5, wd=0xDEAD_BEEF, ra1=5 same cycle -> rd1=0xDEAD_BEEF that cycle; next cycle wvalid=0, rd1 still 0xDEAD_BEEF.
REQ-029 wvalid=1, wa=0, wd=0x1234; ra1=0 -> rd1=0 same cycle and after; busy_cnt stays 0.
REQ-030 set_valid=1, set_addr=7 -> next cycle ra1=7 gives busy1=1, busy_cnt=1; then wvalid=1, wa=7, wd=9 -> same cycle busy1=0, rd1=9; next cycle busy_cnt=0.
REQ-031 busy[3]=1; same cycle set_valid=1, set_addr=3 and wvalid=1, wa=3 -> after edge busy[3]=1, busy_cnt unchanged, register 3 holds wd.
REQ-032 Set registers 1,2,4 over three cycles (busy_cnt=3); assert flush with set_valid, set_addr=6 -> after edge busy_cnt=0, busy2=0 for ra2=6.
REQ-033 Write 0xFF to register 10 and mark busy 11; assert reset=0 one cycle with wvalid=1, wa=12 -> after edge registers 10 and 12 read 0, busy_cnt=0.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_scoreboard_pkg                                     |
// | Description : Shared types, widths and helpers for the register file     |
// |               and its busy scoreboard.                                   |
// | Contents    : creg_addr_t (5-bit register address), u64, u1,             |
// |               busy_cnt_t / BUSY_CNT_W (pending-register count),          |
// |               busy_vec_t (one busy bit per register), popcount().        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package regfile_scoreboard_pkg;

  localparam int NUM_REGS    = 32;
  localparam int CREG_ADDR_W = 5;
  // 6 bits so the count can represent every possible pending register.
  localparam int BUSY_CNT_W  = 6;

  typedef logic [CREG_ADDR_W-1:0] creg_addr_t;
  typedef logic [63:0]            u64;
  typedef logic                   u1;
  typedef logic [BUSY_CNT_W-1:0]  busy_cnt_t;
  typedef logic [NUM_REGS-1:0]    busy_vec_t;

  // Number of set bits in a busy vector.
  function automatic busy_cnt_t popcount(input busy_vec_t v);
    busy_cnt_t c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + busy_cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage : regfile_scoreboard_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_scoreboard_if                                      |
// | Description : Bundles the write port, decode read ports, issue-time set  |
// |               port, flush and busy outputs of the register file.         |
// | Modports    : master - drives wa/wd/wvalid, ra1/ra2, set_valid/set_addr, |
// |                        flush; observes rd1/rd2, busy1/busy2, busy_cnt.   |
// |               slave  - the register file side (directions reversed).     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  // Writeback port
  creg_addr_t wa;
  u64         wd;
  u1          wvalid;
  // Decode read ports
  creg_addr_t ra1;
  creg_addr_t ra2;
  u64         rd1;
  u64         rd2;
  u1          busy1;
  u1          busy2;
  // Issue-time pending mark and squash
  u1          set_valid;
  creg_addr_t set_addr;
  u1          flush;
  busy_cnt_t  busy_cnt;

  modport master (
    output wa, wd, wvalid, ra1, ra2, set_valid, set_addr, flush,
    input  rd1, rd2, busy1, busy2, busy_cnt
  );

  modport slave (
    input  wa, wd, wvalid, ra1, ra2, set_valid, set_addr, flush,
    output rd1, rd2, busy1, busy2, busy_cnt
  );

endinterface : regfile_scoreboard_if
`default_nettype wire

// File: rtl/regfile_scoreboard_busy_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : busy_scoreboard                                            |
// | Description : One pending bit per architectural register plus a          |
// |               registered count of pending registers.                     |
// | Ports       : clk, reset (sync, active-low)                              |
// |               wa/wvalid        - writeback clears the pending mark       |
// |               set_valid/set_addr - issue marks a destination pending     |
// |               flush            - squash clears every pending mark        |
// |               ra1/ra2 -> busy1/busy2 - pending status for decode reads   |
// |               busy_cnt         - pending register count                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module busy_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire creg_addr_t wa,
  input  wire u1          wvalid,
  input  wire u1          set_valid,
  input  wire creg_addr_t set_addr,
  input  wire u1          flush,
  input  wire creg_addr_t ra1,
  input  wire creg_addr_t ra2,
  output      u1          busy1,
  output      u1          busy2,
  output      busy_cnt_t  busy_cnt
);

  busy_vec_t busy_q;
  busy_vec_t busy_d;
  busy_cnt_t cnt_q;
  busy_cnt_t cnt_d;
  u1         wb_active;

  assign wb_active = wvalid && (wa != '0);

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      // Clear first, then set, so a same-cycle set to the same register wins.
      if (wb_active) begin
        busy_d[wa] = 1'b0;
      end
      if (set_valid && (set_addr != '0)) begin
        busy_d[set_addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
    // Count taken from the next-state vector so it tracks the bits with
    // no extra cycle of latency.
    cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // A producer writing back this very cycle is no longer a hazard: the
  // value is forwarded on the read port. busy_q[0] is always 0, so ra==0
  // never reports busy.
  assign busy1    = busy_q[ra1] & ~(wb_active && (wa == ra1));
  assign busy2    = busy_q[ra2] & ~(wb_active && (wa == ra2));
  assign busy_cnt = cnt_q;

endmodule : busy_scoreboard
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_scoreboard                                         |
// | Description : 32 x 64-bit architectural register file with write-to-read |
// |               bypass and an attached busy scoreboard.                    |
// | Ports       : clk   - clock, all state on rising edge                    |
// |               reset - synchronous active-low reset                       |
// |               bus   - regfile_scoreboard_if.slave: write port, two read  |
// |                       ports with busy flags, set/flush, busy_cnt         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input wire logic            clk,
  input wire logic            reset,
  regfile_scoreboard_if.slave bus
);

  u64 regs_q [NUM_REGS];
  u64 regs_d [NUM_REGS];
  u1  wb_active;

  // Register 0 is hardwired to zero, so writes to it are dropped here.
  assign wb_active = bus.wvalid && (bus.wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wb_active) begin
      regs_d[bus.wa] = bus.wd;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read with same-cycle forwarding of the writeback data.
  always_comb begin
    if (bus.ra1 == '0) begin
      bus.rd1 = '0;
    end else if (wb_active && (bus.wa == bus.ra1)) begin
      bus.rd1 = bus.wd;
    end else begin
      bus.rd1 = regs_q[bus.ra1];
    end
  end

  always_comb begin
    if (bus.ra2 == '0) begin
      bus.rd2 = '0;
    end else if (wb_active && (bus.wa == bus.ra2)) begin
      bus.rd2 = bus.wd;
    end else begin
      bus.rd2 = regs_q[bus.ra2];
    end
  end

  busy_scoreboard u_busy_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .wa        (bus.wa),
    .wvalid    (bus.wvalid),
    .set_valid (bus.set_valid),
    .set_addr  (bus.set_addr),
    .flush     (bus.flush),
    .ra1       (bus.ra1),
    .ra2       (bus.ra2),
    .busy1     (bus.busy1),
    .busy2     (bus.busy2),
    .busy_cnt  (bus.busy_cnt)
  );

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_regfile_scoreboard                                      |
// | Description : Directed testbench. The driver applies inputs just after a |
// |               rising edge and queues the outputs it expects for that     |
// |               cycle; a monitor drains the queue at the falling edge and  |
// |               compares against the DUT.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  localparam int W_RD1 = 0;
  localparam int W_RD2 = 1;
  localparam int W_B1  = 2;
  localparam int W_B2  = 3;
  localparam int W_CNT = 4;

  typedef struct {
    string       name;
    int          what;
    logic [63:0] val;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: at each falling edge, check every expectation queued this cycle.
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.what)
          W_RD1:   act = bus.rd1;
          W_RD2:   act = bus.rd2;
          W_B1:    act = {63'd0, bus.busy1};
          W_B2:    act = {63'd0, bus.busy2};
          default: act = {58'd0, bus.busy_cnt};
        endcase
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_out(input string name, input int what, input logic [63:0] val);
    exp_t e;
    e.name = name;
    e.what = what;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.wvalid    = 1'b0;
    bus.wa        = '0;
    bus.wd        = '0;
    bus.set_valid = 1'b0;
    bus.set_addr  = '0;
    bus.flush     = 1'b0;
  endtask

  // Advance one clock; new inputs are applied 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle();
    bus.ra1  = '0;
    bus.ra2  = '0;
    step();
    step();
    reset = 1'b1;

    // Reset state
    bus.ra1 = 5'd5;
    bus.ra2 = 5'd31;
    expect_out("rst_rd1", W_RD1, 64'd0);
    expect_out("rst_rd2", W_RD2, 64'd0);
    expect_out("rst_b1", W_B1, 64'd0);
    expect_out("rst_b2", W_B2, 64'd0);
    expect_out("rst_cnt", W_CNT, 64'd0);
    step();

    // Write with same-cycle bypass, then stored value
    bus.wvalid = 1'b1; bus.wa = 5'd5; bus.wd = 64'hDEAD_BEEF; bus.ra1 = 5'd5;
    expect_out("bypass_rd1", W_RD1, 64'hDEAD_BEEF);
    step();
    idle();
    bus.ra2 = 5'd5;
    expect_out("stored_rd1", W_RD1, 64'hDEAD_BEEF);
    expect_out("stored_rd2", W_RD2, 64'hDEAD_BEEF);
    step();

    // Register 0 write is discarded
    bus.wvalid = 1'b1; bus.wa = 5'd0; bus.wd = 64'h1234; bus.ra1 = 5'd0;
    expect_out("r0_bypass", W_RD1, 64'd0);
    step();
    idle();
    expect_out("r0_after", W_RD1, 64'd0);
    expect_out("r0_cnt", W_CNT, 64'd0);
    step();

    // Set busy 7, then write 7 clears it with bypass
    bus.set_valid = 1'b1; bus.set_addr = 5'd7; bus.ra1 = 5'd7;
    expect_out("set7_pre_b1", W_B1, 64'd0);
    step();
    idle();
    expect_out("set7_b1", W_B1, 64'd1);
    expect_out("set7_cnt", W_CNT, 64'd1);
    step();
    bus.wvalid = 1'b1; bus.wa = 5'd7; bus.wd = 64'd9;
    expect_out("wb7_b1", W_B1, 64'd0);
    expect_out("wb7_rd1", W_RD1, 64'd9);
    expect_out("wb7_cnt_pre", W_CNT, 64'd1);
    step();
    idle();
    expect_out("wb7_cnt", W_CNT, 64'd0);
    expect_out("wb7_rd1_stored", W_RD1, 64'd9);
    step();

    // Set wins over a same-cycle clear of the same register
    bus.set_valid = 1'b1; bus.set_addr = 5'd3;
    step();
    idle();
    expect_out("set3_cnt", W_CNT, 64'd1);
    bus.set_valid = 1'b1; bus.set_addr = 5'd3;
    bus.wvalid = 1'b1; bus.wa = 5'd3; bus.wd = 64'h33; bus.ra1 = 5'd3;
    expect_out("setclr_b1_bypass", W_B1, 64'd0);
    expect_out("setclr_rd1_bypass", W_RD1, 64'h33);
    step();
    idle();
    expect_out("setclr_b1", W_B1, 64'd1);
    expect_out("setclr_cnt", W_CNT, 64'd1);
    expect_out("setclr_rd1", W_RD1, 64'h33);
    // Re-setting a busy register must not change the count
    bus.set_valid = 1'b1; bus.set_addr = 5'd3;
    step();
    idle();
    expect_out("reset_busy_cnt", W_CNT, 64'd1);
    bus.wvalid = 1'b1; bus.wa = 5'd3; bus.wd = 64'h34;
    step();
    idle();
    expect_out("clr3_cnt", W_CNT, 64'd0);
    // Clearing a non-busy register must not wrap the count
    bus.wvalid = 1'b1; bus.wa = 5'd8; bus.wd = 64'h88;
    step();
    idle();
    expect_out("clr_idle_cnt", W_CNT, 64'd0);
    // set_addr 0 is ignored
    bus.set_valid = 1'b1; bus.set_addr = 5'd0;
    step();
    idle();
    bus.ra2 = 5'd0;
    expect_out("set0_cnt", W_CNT, 64'd0);
    expect_out("set0_b2", W_B2, 64'd0);
    step();

    // Flush beats a concurrent set; a concurrent write still lands
    for (int i = 0; i < 3; i++) begin
      bus.set_valid = 1'b1;
      bus.set_addr  = (i == 2) ? 5'd4 : creg_addr_t'(i + 1);
      step();
    end
    idle();
    bus.ra1 = 5'd2;
    expect_out("three_cnt", W_CNT, 64'd3);
    expect_out("three_b1", W_B1, 64'd1);
    bus.flush = 1'b1; bus.set_valid = 1'b1; bus.set_addr = 5'd6;
    bus.wvalid = 1'b1; bus.wa = 5'd9; bus.wd = 64'h99;
    step();
    idle();
    bus.ra1 = 5'd9; bus.ra2 = 5'd6;
    expect_out("flush_cnt", W_CNT, 64'd0);
    expect_out("flush_b2", W_B2, 64'd0);
    expect_out("flush_wr_rd1", W_RD1, 64'h99);
    step();

    // Reset overrides write and set
    bus.wvalid = 1'b1; bus.wa = 5'd10; bus.wd = 64'hFF;
    step();
    idle();
    bus.set_valid = 1'b1; bus.set_addr = 5'd11;
    step();
    idle();
    bus.ra1 = 5'd10; bus.ra2 = 5'd11;
    expect_out("pre_rst_rd1", W_RD1, 64'hFF);
    expect_out("pre_rst_b2", W_B2, 64'd1);
    expect_out("pre_rst_cnt", W_CNT, 64'd1);
    step();
    reset = 1'b0;
    bus.wvalid = 1'b1; bus.wa = 5'd12; bus.wd = 64'hABC;
    bus.set_valid = 1'b1; bus.set_addr = 5'd13;
    step();
    reset = 1'b1;
    idle();
    bus.ra1 = 5'd10; bus.ra2 = 5'd12;
    expect_out("post_rst_rd10", W_RD1, 64'd0);
    expect_out("post_rst_rd12", W_RD2, 64'd0);
    expect_out("post_rst_cnt", W_CNT, 64'd0);
    step();
    bus.ra1 = 5'd13; bus.ra2 = 5'd11;
    expect_out("post_rst_b13", W_B1, 64'd0);
    expect_out("post_rst_b11", W_B2, 64'd0);
    step();
    step();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_scoreboard
`default_nettype wire
